// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, single-outstanding imem requester and a 2-entry
// {pc, inst} queue to decode. Optional fetch freeze is built with INST_FETCH_HALT_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_next_clk,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        halt,
    output logic        halted
);
    typedef enum logic [1:0] {RUN = 2'd0, DROP = 2'd1, HALT = 2'd2} state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s, pc_inc_s, target_s;
    logic        req_r, req_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic        head_vld_r, tail_vld_r;
    logic [31:0] head_pc_r, head_inst_r, tail_pc_r, tail_inst_r;
    logic        ack_s, pop_s, push_s, flush_s, halt_s;
    logic        room_push_s, room_hold_s;
    logic [1:0]  unused_pc_lsb_s;

`ifdef INST_FETCH_HALT_EN
    logic        halted_r;
    assign halt_s = halt;
    assign halted = halted_r;
`else
    logic        unused_halt_s;
    assign halt_s        = 1'b0;
    assign unused_halt_s = halt;
    assign halted        = 1'b0;
`endif

    assign unused_pc_lsb_s = PC_next_clk[1:0];
    assign target_s        = {PC_next_clk[31:2], 2'b00};
    assign pc_inc_s        = pc_r + 32'd4;
    // Acks are only meaningful while a request is actually outstanding.
    assign ack_s           = req_r & imem_ack;
    assign pop_s           = head_vld_r & id_ready;
    // Queue has a free slot after this edge, with or without a push.
    assign room_push_s     = ~head_vld_r | (pop_s & ~tail_vld_r);
    assign room_hold_s     = ~tail_vld_r | pop_s;

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign id_valid  = head_vld_r;
    assign id_inst   = head_inst_r;
    assign id_pc     = head_pc_r;

    // Next-state, next-PC and next-request decision.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        req_nxt_s   = req_r;
        addr_nxt_s  = addr_r;
        flush_s     = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (redirect) begin
                    flush_s  = 1'b1;
                    pc_nxt_s = target_s;
                    if (req_r && !imem_ack) begin
                        state_nxt_s = DROP;
                    end else begin
                        req_nxt_s  = 1'b1;
                        addr_nxt_s = target_s;
                    end
                end else if (ack_s) begin
                    push_s   = 1'b1;
                    pc_nxt_s = pc_inc_s;
                    if (halt_s) begin
                        state_nxt_s = HALT;
                        req_nxt_s   = 1'b0;
                    end else begin
                        req_nxt_s  = room_push_s;
                        addr_nxt_s = pc_inc_s;
                    end
                end else if (req_r) begin
                    req_nxt_s = 1'b1;
                end else if (halt_s) begin
                    state_nxt_s = HALT;
                end else begin
                    req_nxt_s  = room_hold_s;
                    addr_nxt_s = pc_r;
                end
            end
            DROP: begin
                // The stale request stays on the bus until it completes.
                if (redirect) begin
                    flush_s  = 1'b1;
                    pc_nxt_s = target_s;
                    if (ack_s) begin
                        state_nxt_s = RUN;
                        addr_nxt_s  = target_s;
                    end else begin
                        state_nxt_s = DROP;
                    end
                end else if (ack_s) begin
                    state_nxt_s = RUN;
                    req_nxt_s   = ~halt_s;
                    addr_nxt_s  = pc_r;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            HALT: begin
                if (redirect) begin
                    flush_s  = 1'b1;
                    pc_nxt_s = target_s;
                    if (!halt_s) begin
                        state_nxt_s = RUN;
                        req_nxt_s   = 1'b1;
                        addr_nxt_s  = target_s;
                    end else begin
                        state_nxt_s = HALT;
                    end
                end else if (!halt_s) begin
                    state_nxt_s = RUN;
                    req_nxt_s   = room_hold_s;
                    addr_nxt_s  = pc_r;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: begin
                state_nxt_s = RUN;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, PC, request and queue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            pc_r        <= RESET_PC;
            req_r       <= 1'b0;
            addr_r      <= 32'd0;
            head_vld_r  <= 1'b0;
            tail_vld_r  <= 1'b0;
            head_pc_r   <= 32'd0;
            head_inst_r <= 32'd0;
            tail_pc_r   <= 32'd0;
            tail_inst_r <= 32'd0;
`ifdef INST_FETCH_HALT_EN
            halted_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            req_r   <= req_nxt_s;
            addr_r  <= addr_nxt_s;
`ifdef INST_FETCH_HALT_EN
            halted_r <= (state_nxt_s == HALT);
`endif
            if (flush_s) begin
                head_vld_r <= 1'b0;
                tail_vld_r <= 1'b0;
            end else begin
                // Head slot is always the oldest entry; pops shift tail forward.
                case ({push_s, pop_s})
                    2'b11: begin
                        if (tail_vld_r) begin
                            head_pc_r   <= tail_pc_r;
                            head_inst_r <= tail_inst_r;
                            tail_pc_r   <= pc_r;
                            tail_inst_r <= imem_rdata;
                        end else begin
                            head_pc_r   <= pc_r;
                            head_inst_r <= imem_rdata;
                        end
                    end
                    2'b10: begin
                        if (!head_vld_r) begin
                            head_vld_r  <= 1'b1;
                            head_pc_r   <= pc_r;
                            head_inst_r <= imem_rdata;
                        end else begin
                            tail_vld_r  <= 1'b1;
                            tail_pc_r   <= pc_r;
                            tail_inst_r <= imem_rdata;
                        end
                    end
                    2'b01: begin
                        if (tail_vld_r) begin
                            head_pc_r   <= tail_pc_r;
                            head_inst_r <= tail_inst_r;
                            tail_vld_r  <= 1'b0;
                        end else begin
                            head_vld_r  <= 1'b0;
                        end
                    end
                    default: begin
                        head_vld_r <= head_vld_r;
                    end
                endcase
            end
        end
    end
endmodule
